// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of programmable tick / square-wave dividers with glitch-free reload
// Optional build macro: CLOCK_DIVIDER_BANK_PHASE_SYNC_EN adds the sync_all phase-alignment input.
module clock_divider_bank #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          NUM_BITS     = 26,
  parameter int unsigned DEFAULT_MOD  = 50_000_000,
  parameter int          CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] ch_enable,
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
  input  logic                    sync_all,
`endif
  input  logic                    load,
  input  logic [CH_BITS-1:0]      load_channel,
  input  logic [NUM_BITS-1:0]     load_mod,
  input  logic                    load_mode,
  output logic                    load_ready,
  output logic [NUM_CHANNELS-1:0] tick_out,
  output logic [NUM_CHANNELS-1:0] clock_out
);

  logic [NUM_CHANNELS-1:0] pending;

  // A channel accepts a new setting only while it has no setting waiting to be applied.
  always_comb begin
    load_ready = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (load_channel == CH_BITS'(i)) begin
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
        load_ready = !pending[i] || sync_all;
`else
        load_ready = !pending[i];
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [NUM_BITS-1:0] count;
    logic [NUM_BITS-1:0] mod;
    logic [NUM_BITS-1:0] eff_mod;
    logic [NUM_BITS-1:0] shadow_mod;
    logic                mode;
    logic                shadow_mode;
    logic                pending_r;
    logic                tick_r;
    logic                clock_r;
    logic                advance;
    logic                wrap;
    logic                accept;

    always_comb begin
      eff_mod = (mod == '0) ? NUM_BITS'(1) : mod;
      advance = enable && ch_enable[g];
      wrap    = advance && (count >= eff_mod - NUM_BITS'(1));
      accept  = load && load_ready && (load_channel == CH_BITS'(g));
    end

    always_ff @(posedge clock_in) begin
      if (reset) begin
        count       <= '0;
        mod         <= NUM_BITS'(DEFAULT_MOD);
        mode        <= 1'b0;
        shadow_mod  <= NUM_BITS'(DEFAULT_MOD);
        shadow_mode <= 1'b0;
        pending_r   <= 1'b0;
        tick_r      <= 1'b0;
        clock_r     <= 1'b0;
      end
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
      else if (sync_all) begin
        count   <= '0;
        tick_r  <= 1'b0;
        clock_r <= 1'b0;
        if (pending_r) begin
          mod       <= shadow_mod;
          mode      <= shadow_mode;
          pending_r <= 1'b0;
        end
        if (accept) begin
          shadow_mod  <= load_mod;
          shadow_mode <= load_mode;
          pending_r   <= 1'b1;
        end
      end
`endif
      else begin
        tick_r <= wrap;
        if (pending_r && !ch_enable[g]) begin
          // Parked channel: no wrap will come, so take the new setting right away.
          mod       <= shadow_mod;
          mode      <= shadow_mode;
          pending_r <= 1'b0;
          count     <= '0;
          clock_r   <= 1'b0;
        end else if (wrap) begin
          count <= '0;
          if (pending_r) begin
            mod       <= shadow_mod;
            mode      <= shadow_mode;
            pending_r <= 1'b0;
            if (shadow_mode != mode) clock_r <= 1'b0;
            else if (mode)           clock_r <= !clock_r;
            else                     clock_r <= 1'b1;
          end else if (mode) begin
            clock_r <= !clock_r;
          end else begin
            clock_r <= 1'b1;
          end
        end else begin
          if (advance) count <= count + NUM_BITS'(1);
          if (!mode)   clock_r <= 1'b0;
        end
        // Accept never collides with an apply: it requires pending_r to be clear.
        if (accept) begin
          shadow_mod  <= load_mod;
          shadow_mode <= load_mode;
          pending_r   <= 1'b1;
        end
      end
    end

    assign pending[g]   = pending_r;
    assign tick_out[g]  = tick_r;
    assign clock_out[g] = clock_r;
  end

endmodule
